dac_frame_streamer: RTL and testbench

Parametrised multi-channel sample streamer between the RISC-V core and one or more DAC inputs. It replaces the direct core-to-DAC word connection.
- Accepts full sample frames (one word per channel) over a valid/ready handshake and buffers them in a FIFO.
- Presents each frame to the DAC word inputs at a programmable update rate derived from the PLL clock.
- Handles underflow deterministically and reports it through a sticky flag.

---
 rtl/dac_frame_streamer.sv | 88 ++++++++
 tb/tb_dac_frame_streamer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dac_frame_streamer.sv
// Multi-channel DAC sample streamer: frame FIFO drained at a programmable tick rate,
// with a sticky underflow flag and hold/midscale underflow behaviour.
module dac_frame_streamer #(
    parameter int DATA_W     = 10,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic [NUM_CH*DATA_W-1:0]       IN_DATA,
    input  logic                           IN_VALID,
    output logic                           IN_READY,
    input  logic                           EN,
    input  logic [DIV_W-1:0]               RATE_DIV,
    input  logic                           UNDERFLOW_MODE,
    input  logic                           UNDERFLOW_CLR,
    output logic [NUM_CH*DATA_W-1:0]       OUT_D,
    output logic                           OUT_STB,
    output logic                           UNDERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]    FIFO_LEVEL
);
    localparam int FW = NUM_CH * DATA_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    logic [FW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [DIV_W-1:0] count;
    logic [FW-1:0]    midscale;
    logic             push, pop, tick, empty;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_mid
        assign midscale[k*DATA_W +: DATA_W] = MID;
    end

    // Ready and empty come from registered level only, so a frame pushed this
    // cycle can never be popped by a tick in the same cycle.
    assign IN_READY = (FIFO_LEVEL != LW'(FIFO_DEPTH));
    assign empty    = (FIFO_LEVEL == '0);
    assign push     = IN_VALID && IN_READY;
    assign tick     = EN && (count >= RATE_DIV);
    assign pop      = tick && !empty;

    always_ff @(posedge CLK) begin
        if (push && !reset)
            mem[wr_ptr] <= IN_DATA;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
            count      <= '0;
            OUT_D      <= midscale;
            OUT_STB    <= 1'b0;
            UNDERFLOW  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                FIFO_LEVEL <= FIFO_LEVEL + LW'(1);
            else if (pop && !push)
                FIFO_LEVEL <= FIFO_LEVEL - LW'(1);

            if (!EN || tick)
                count <= '0;
            else
                count <= count + DIV_W'(1);

            OUT_STB <= tick;
            if (pop)
                OUT_D <= mem[rd_ptr];
            else if (tick && UNDERFLOW_MODE)
                OUT_D <= midscale;

            // A new underflow wins over a simultaneous clear.
            if (tick && empty)
                UNDERFLOW <= 1'b1;
            else if (UNDERFLOW_CLR)
                UNDERFLOW <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dac_frame_streamer.sv
// Directed + randomized bench for dac_frame_streamer against a queue-based frame model.
module tb_dac_frame_streamer;
    localparam int DATA_W = 10, NUM_CH = 2, DEPTH = 4, DIV_W = 16;
    localparam int FW = DATA_W * NUM_CH;
    localparam logic [FW-1:0] MIDF = {10'h200, 10'h200};

    logic             CLK = 1'b0;
    logic             reset = 1'b0;
    logic [FW-1:0]    in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             en = 1'b0;
    logic [DIV_W-1:0] rate_div = '0;
    logic             mode = 1'b0;
    logic             clr = 1'b0;
    logic [FW-1:0]    out_d;
    logic             out_stb;
    logic             underflow;
    logic [2:0]       fifo_level;

    dac_frame_streamer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .CLK(CLK), .reset(reset), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
        .EN(en), .RATE_DIV(rate_div), .UNDERFLOW_MODE(mode), .UNDERFLOW_CLR(clr),
        .OUT_D(out_d), .OUT_STB(out_stb), .UNDERFLOW(underflow), .FIFO_LEVEL(fifo_level)
    );

    always #5 CLK = ~CLK;

    // Reference model: frames as a queue, divider as elapsed enabled cycles.
    logic [FW-1:0] q[$];
    int            m_elapsed = 0;
    logic [FW-1:0] m_out = MIDF;
    logic          m_stb = 1'b0;
    logic          m_uf = 1'b0;
    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit was_empty, acc, tk;
        if (reset) begin
            q.delete();
            m_elapsed = 0; m_out = MIDF; m_stb = 0; m_uf = 0;
            return;
        end
        was_empty = (q.size() == 0);
        acc = in_valid && (q.size() != DEPTH);
        tk  = en && (m_elapsed >= int'(rate_div));
        if (tk) begin
            if (!was_empty) m_out = q.pop_front();
            else if (mode) m_out = MIDF;
        end
        if (acc) q.push_back(in_data);
        m_stb = tk;
        if (tk && was_empty) m_uf = 1;
        else if (clr) m_uf = 0;
        m_elapsed = (!en || tk) ? 0 : m_elapsed + 1;
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        check("out_d", 32'(out_d), 32'(m_out));
        check("out_stb", 32'(out_stb), 32'(m_stb));
        check("underflow", 32'(underflow), 32'(m_uf));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 1; in_data = 20'hABCDE; en = 0; clr = 0;
        step();
        reset = 0; in_valid = 0;
    endtask

    task automatic push(input logic [FW-1:0] d);
        in_valid = 1; in_data = d; step(); in_valid = 0;
    endtask

    task automatic scen2(input logic m);
        do_reset();
        mode = m;
        push({10'h001, 10'h3FF});
        push({10'h155, 10'h2AA});
        rate_div = 3; en = 1;
        repeat (12) step();
        check("s2_final_d", 32'(out_d), m ? 32'(MIDF) : 32'({10'h155, 10'h2AA}));
        check("s2_uf", 32'(underflow), 32'd1);
        en = 0;
    endtask

    initial begin
        // 1: reset then idle
        do_reset();
        check("rst_mid", 32'(out_d), 32'h80200);
        repeat (5) step();

        // 2/3: two frames, underflow hold vs midscale, then clear without tick
        scen2(1'b0);
        scen2(1'b1);
        clr = 1; step(); clr = 0; step();
        check("clr_uf", 32'(underflow), 32'd0);

        // 4: fill to full, reject 5th, drain at full rate, three refills
        do_reset(); mode = 0;
        for (int r = 0; r < 4; r++) begin
            en = 0;
            for (int i = 0; i < 5; i++) push(FW'($urandom));
            check("full_lvl", 32'(fifo_level), 32'd4);
            check("full_rdy", 32'(in_ready), 32'd0);
            rate_div = 0; en = 1;
            repeat (6) step();
        end

        // 5: streaming with valid held high every cycle
        do_reset();
        rate_div = 0; en = 1; in_valid = 1;
        for (int i = 0; i < 12; i++) begin
            in_data = FW'($urandom);
            step();
            if (i == 0) check("s5_first_uf", 32'(underflow), 32'd1);
            check("s5_lvl_le1", 32'(fifo_level <= 1), 32'd1);
        end
        in_valid = 0; en = 0;

        // 6: reset mid-stream at level 3
        do_reset();
        for (int i = 0; i < 3; i++) push(FW'($urandom));
        check("s6_lvl3", 32'(fifo_level), 32'd3);
        do_reset();
        check("s6_lvl0", 32'(fifo_level), 32'd0);
        rate_div = 1; en = 1;
        repeat (3) step();
        check("s6_uf", 32'(underflow), 32'd1);

        // Random mix of all controls including occasional reset
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 49) == 0);
            in_valid = $urandom_range(0, 1);
            in_data  = FW'($urandom);
            en       = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) rate_div = DIV_W'($urandom_range(0, 4));
            mode     = $urandom_range(0, 1);
            clr      = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
